gpu_rect_scan_ctrl: RTL and testbench
=====================================

// Module: gpu_rect_scan_ctrl
// PURPOSE
//   Sequencer for rectangle/fill rasterisation: walks a screen-space box in horizontal
//   2-pixel pairs, top to bottom, and emits one pair per valid/ready handshake to the
//   pixel pipeline. Handles even-X pair alignment, per-pair edge masking and
//   interlaced-field line skipping. Sits between the command decoder and the pixel write path.
// PARAMETERS
//   COORD_W   12   signed coordinate width (X/Y in, X/Y out)
// PORTS
//   i_clk            in   1        clock; single clock domain
//   i_rst            in   1        synchronous reset, active-high
//   i_start          in   1        start pulse; sampled only in IDLE
//   i_abort          in   1        cancel current scan
//   i_x0             in   COORD_W  signed left X (inclusive)
//   i_y0             in   COORD_W  signed top Y (inclusive)
//   i_width          in   11       width in pixels, 0..1024
//   i_height         in   10       height in lines, 0..511
//   i_interlaceRender in  1        render only lines of the current field
//   i_currentField   in   1        current interlace field (0/1)
//   o_busy           out  1        high from accepted start until DONE left
//   o_pixelValid     out  1        pair on o_pixelX/Y/o_pairMask is valid
//   i_pixelReady     in   1        downstream accepts pair
//   o_pixelX         out  COORD_W  even X of left pixel of pair
//   o_pixelY         out  COORD_W  Y of pair
//   o_pairMask       out  2        [0]=left pixel inside box, [1]=right pixel inside
//   o_lastPixel      out  1        current pair is the final pair of the box
//   o_done           out  1        one-cycle completion pulse
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; internal registers 0.
//   States: IDLE -> SETUP -> SCAN <-> NEXTLINE -> DONE -> IDLE.
//   IDLE: i_start=1 latches x0,y0,width,height,interlace,field; next SETUP. Start in other states ignored.
//   SETUP (1 cycle): endX=x0+width-1, endY=y0+height-1 (COORD_W+1 bits, no wrap);
//     startX={x0[COORD_W-1:1],1'b0}; off=interlace ? (y0[0]^field) : 0; Y=y0+off.
//     width==0 or height==0 or Y>endY -> DONE (no pairs emitted); else X=startX, SCAN.
//   SCAN: o_pixelValid=1. X/Y/mask/last held stable while valid && !ready.
//     mask[0]=(X>=x0)&&(X<=endX); mask[1]=(X+1>=x0)&&(X+1<=endX).
//     On valid&&ready: if X+2>endX -> NEXTLINE else X<=X+2 (next pair presented next cycle).
//     First pair valid 2 cycles after accepted i_start; back-to-back pairs at 1/cycle with ready=1.
//   NEXTLINE (1 cycle bubble, valid=0): Y<=Y+(interlace?2:1); X<=startX;
//     if new Y>endY -> DONE else SCAN.
//   o_lastPixel=1 in SCAN when X+2>endX and Y+step>endY.
//   DONE: o_done=1 for exactly one cycle, o_busy still 1; next IDLE (busy=0).
//   i_abort (any non-IDLE state, incl. mid-handshake): next cycle IDLE, valid=0, busy=0,
//     no o_done. i_abort has priority over i_start and ready. i_rst overrides all.
//   Comparisons are signed on COORD_W+1 bits; a box crossing +2047 never wraps X/Y.
//   Mask never 2'b00 for an emitted pair.
// TESTING
//   x0=3,y0=10,w=4,h=2,no interlace,ready=1 -> pairs (2,10,m=10)(4,10,11)(6,10,01),
//     same for Y=11; last on (6,11); done 1 cycle after; 6 pairs total.
//   x0=0,y0=5,w=2,h=4,interlace,field=0 -> off=1; pairs at Y=6,8 only, mask 11; done.
//   w=0 or h=0, or interlace x0=0,y0=4,h=1,field=1 -> no valid, o_done 2 cycles after start.
//   ready toggled 1010.. during 8-wide box -> each pair held until accepted, no loss/dup.
//   abort asserted while valid&&!ready on 2nd pair -> idle next cycle, no done; new start works.
//   start pulsed while busy -> ignored; reset mid-SCAN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/gpu_rect_scan_ctrl.sv
// Rectangle scan sequencer: walks a screen-space box in even-aligned 2-pixel pairs,
// top to bottom, with edge masking and optional interlaced-field line skipping.
module gpu_rect_scan_ctrl #(
    parameter int unsigned COORD_W = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [10:0]        i_width,
    input  logic [9:0]         i_height,
    input  logic               i_interlaceRender,
    input  logic               i_currentField,
    output logic               o_busy,
    output logic               o_pixelValid,
    input  logic               i_pixelReady,
    output logic [COORD_W-1:0] o_pixelX,
    output logic [COORD_W-1:0] o_pixelY,
    output logic [1:0]         o_pairMask,
    output logic               o_lastPixel,
    output logic               o_done
);

    localparam int unsigned CW = COORD_W + 1;
    typedef logic signed [CW-1:0] coord_t;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StScan,
        StNextLine,
        StDone
    } state_e;

    state_e state_q, state_d;

    // One extra bit of headroom so box edges past the top of the coordinate range never wrap.
    coord_t      x0_q, y0_q, end_x_q, end_y_q, x_q, y_q;
    logic [10:0] width_q;
    logic [9:0]  height_q;
    logic        interlace_q, field_q;

    coord_t w_ext, h_ext, off_ext, step;
    coord_t end_x_c, end_y_c, start_x_c, y_first_c;
    coord_t x_p1, x_p2, y_step;
    logic   setup_empty, row_end, col_end;

    assign w_ext     = coord_t'({{(CW-11){1'b0}}, width_q});
    assign h_ext     = coord_t'({{(CW-10){1'b0}}, height_q});
    assign off_ext   = coord_t'({{(CW-1){1'b0}}, interlace_q & (y0_q[0] ^ field_q)});
    assign step      = interlace_q ? coord_t'(2) : coord_t'(1);

    assign end_x_c   = x0_q + w_ext - coord_t'(1);
    assign end_y_c   = y0_q + h_ext - coord_t'(1);
    assign start_x_c = {x0_q[CW-1:1], 1'b0};
    assign y_first_c = y0_q + off_ext;

    assign x_p1      = x_q + coord_t'(1);
    assign x_p2      = x_q + coord_t'(2);
    assign y_step    = y_q + step;

    assign setup_empty = (width_q == '0) || (height_q == '0) || (y_first_c > end_y_c);
    assign row_end     = x_p2 > end_x_q;
    assign col_end     = y_step > end_y_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (i_start) state_d = StSetup;
            StSetup:    state_d = setup_empty ? StDone : StScan;
            StScan:     if (i_pixelReady && row_end) state_d = StNextLine;
            StNextLine: state_d = col_end ? StDone : StScan;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        // Abort wins over start and ready alike.
        if (i_abort && state_q != StIdle) state_d = StIdle;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x0_q        <= '0;
            y0_q        <= '0;
            width_q     <= '0;
            height_q    <= '0;
            interlace_q <= 1'b0;
            field_q     <= 1'b0;
            end_x_q     <= '0;
            end_y_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        x0_q        <= coord_t'($signed(i_x0));
                        y0_q        <= coord_t'($signed(i_y0));
                        width_q     <= i_width;
                        height_q    <= i_height;
                        interlace_q <= i_interlaceRender;
                        field_q     <= i_currentField;
                    end
                end
                StSetup: begin
                    end_x_q <= end_x_c;
                    end_y_q <= end_y_c;
                    x_q     <= start_x_c;
                    y_q     <= y_first_c;
                end
                StScan: begin
                    if (i_pixelReady && !row_end) x_q <= x_p2;
                end
                StNextLine: begin
                    x_q <= start_x_c;
                    y_q <= y_step;
                end
                StDone: ;
                default: ;
            endcase
        end
    end

    logic scan;
    assign scan = (state_q == StScan);

    always_comb begin
        o_busy       = (state_q != StIdle);
        o_done       = (state_q == StDone);
        o_pixelValid = scan;
        o_pixelX     = '0;
        o_pixelY     = '0;
        o_pairMask   = '0;
        o_lastPixel  = 1'b0;
        if (scan) begin
            o_pixelX      = x_q[COORD_W-1:0];
            o_pixelY      = y_q[COORD_W-1:0];
            o_pairMask[0] = (x_q >= x0_q) && (x_q <= end_x_q);
            o_pairMask[1] = (x_p1 >= x0_q) && (x_p1 <= end_x_q);
            o_lastPixel   = row_end && col_end;
        end
    end

endmodule

// File: tb/tb_gpu_rect_scan_ctrl.sv
// Scoreboard bench for gpu_rect_scan_ctrl: a box-level reference model fills an expected
// pair queue; a negedge monitor pops and compares every accepted pair and completion pulse.
module tb_gpu_rect_scan_ctrl;

    localparam int W = 12;

    logic          i_clk = 1'b0;
    logic          i_rst, i_start, i_abort;
    logic [W-1:0]  i_x0, i_y0;
    logic [10:0]   i_width;
    logic [9:0]    i_height;
    logic          i_interlaceRender, i_currentField;
    logic          i_pixelReady = 1'b0;
    logic          o_busy, o_pixelValid, o_lastPixel, o_done;
    logic [W-1:0]  o_pixelX, o_pixelY;
    logic [1:0]    o_pairMask;

    gpu_rect_scan_ctrl #(.COORD_W(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_x0(i_x0), .i_y0(i_y0), .i_width(i_width), .i_height(i_height),
        .i_interlaceRender(i_interlaceRender), .i_currentField(i_currentField),
        .o_busy(o_busy), .o_pixelValid(o_pixelValid), .i_pixelReady(i_pixelReady),
        .o_pixelX(o_pixelX), .o_pixelY(o_pixelY), .o_pairMask(o_pairMask),
        .o_lastPixel(o_lastPixel), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int       x;
        int       y;
        logic [1:0] m;
        bit       last;
    } pair_t;

    pair_t exp_q[$];
    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int exp_done = 0;
    int ready_mode = 0;   // 0 always, 1 toggle, 2 random, else manual
    bit manual_ready = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference: enumerate the pairs the box should produce, straight from the box rules.
    task automatic model_box(input int x0, input int y0, input int w, input int h,
                             input bit il, input bit fld);
        int ex, ey, sx, off, st, n;
        pair_t p;
        if (w == 0 || h == 0) return;
        ex  = x0 + w - 1;
        ey  = y0 + h - 1;
        sx  = x0 & ~1;
        off = il ? ((y0 & 1) ^ int'(fld)) : 0;
        st  = il ? 2 : 1;
        n   = exp_q.size();
        for (int y = y0 + off; y <= ey; y += st) begin
            for (int x = sx; x <= ex; x += 2) begin
                p.x    = x;
                p.y    = y;
                p.m[0] = (x >= x0) && (x <= ex);
                p.m[1] = (x + 1 >= x0) && (x + 1 <= ex);
                p.last = 1'b0;
                exp_q.push_back(p);
            end
        end
        if (exp_q.size() > n) exp_q[exp_q.size()-1].last = 1'b1;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start(input int x0, input int y0, input int w, input int h,
                               input bit il, input bit fld);
        i_x0 = W'(x0);
        i_y0 = W'(y0);
        i_width = 11'(w);
        i_height = 10'(h);
        i_interlaceRender = il;
        i_currentField = fld;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic start_box(input int x0, input int y0, input int w, input int h,
                             input bit il, input bit fld);
        model_box(x0, y0, w, h, il, fld);
        exp_done++;
        pulse_start(x0, y0, w, h, il, fld);
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget && done_seen < exp_done; c++) step();
        check("done_count", done_seen, exp_done);
        check("pairs_left", exp_q.size(), 0);
        step();
        check("busy_after_done", int'(o_busy), 0);
    endtask

    // Ready driven slightly after the stimulus so manual changes land deterministically.
    always begin
        @(posedge i_clk);
        #2;
        case (ready_mode)
            0: i_pixelReady = 1'b1;
            1: i_pixelReady = ~i_pixelReady;
            2: i_pixelReady = 1'($urandom_range(0, 1));
            default: i_pixelReady = manual_ready;
        endcase
    end

    logic [W-1:0] h_x, h_y;
    logic [1:0]   h_m;
    logic         h_l;
    bit           held = 1'b0;

    always @(negedge i_clk) begin
        pair_t p;
        logic [31:0] px, py;
        if (!i_rst) begin
            if (o_pixelValid) begin
                if (held) begin
                    check("hold_x", int'(o_pixelX), int'(h_x));
                    check("hold_y", int'(o_pixelY), int'(h_y));
                    check("hold_mask", int'(o_pairMask), int'(h_m));
                    check("hold_last", int'(o_lastPixel), int'(h_l));
                end
                if (i_pixelReady) begin
                    if (exp_q.size() == 0) begin
                        check("extra_pair", 1, 0);
                    end else begin
                        p  = exp_q.pop_front();
                        px = p.x;
                        py = p.y;
                        check("pair_x", int'(o_pixelX), int'(px[W-1:0]));
                        check("pair_y", int'(o_pixelY), int'(py[W-1:0]));
                        check("pair_mask", int'(o_pairMask), int'(p.m));
                        check("pair_last", int'(o_lastPixel), int'(p.last));
                    end
                end
                held = !i_pixelReady;
                h_x = o_pixelX;
                h_y = o_pixelY;
                h_m = o_pairMask;
                h_l = o_lastPixel;
            end else begin
                held = 1'b0;
            end
            if (o_done) begin
                done_seen++;
                check("done_with_pairs_left", exp_q.size(), 0);
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        int x0, y0, w, h;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_x0 = '0;
        i_y0 = '0;
        i_width = '0;
        i_height = '0;
        i_interlaceRender = 1'b0;
        i_currentField = 1'b0;
        step();
        step();
        check("rst_busy", int'(o_busy), 0);
        check("rst_valid", int'(o_pixelValid), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_xy", int'({o_pixelX, o_pixelY}), 0);
        check("rst_mask_last", int'({o_pairMask, o_lastPixel}), 0);
        i_rst = 1'b0;
        step();

        // Basic box: first pair two cycles after start, six pairs, last on (6,11).
        ready_mode = 0;
        start_box(3, 10, 4, 2, 1'b0, 1'b0);
        check("setup_busy", int'(o_busy), 1);
        step();
        check("first_valid_lat", int'(o_pixelValid), 1);
        wait_done(40);

        // Interlaced field 0 from odd y0: only lines 6 and 8.
        start_box(0, 5, 2, 4, 1'b1, 1'b0);
        wait_done(40);

        // Empty boxes: done exactly two cycles after start, never valid.
        for (int k = 0; k < 3; k++) begin
            if (k == 0) start_box(5, 5, 0, 3, 1'b0, 1'b0);
            else if (k == 1) start_box(5, 5, 4, 0, 1'b0, 1'b0);
            else start_box(0, 4, 4, 1, 1'b1, 1'b1);
            check("empty_no_valid", int'(o_pixelValid), 0);
            step();
            check("empty_done_lat", int'(o_done), 1);
            check("empty_busy_in_done", int'(o_busy), 1);
            wait_done(10);
        end

        // Toggled ready on an 8-wide box, with an ignored start mid-scan.
        ready_mode = 1;
        start_box(1, 20, 8, 3, 1'b0, 1'b0);
        step();
        step();
        pulse_start(100, 100, 30, 5, 1'b0, 1'b0);
        wait_done(80);

        // Abort while the second pair is stalled.
        ready_mode = 3;
        manual_ready = 1'b1;
        start_box(0, 0, 8, 2, 1'b0, 1'b0);
        step();
        step();
        manual_ready = 1'b0;
        step();
        check("abort_pre_valid", int'(o_pixelValid), 1);
        check("abort_pre_x", int'(o_pixelX), 2);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check("abort_valid", int'(o_pixelValid), 0);
        check("abort_busy", int'(o_busy), 0);
        exp_done--;
        exp_q.delete();
        step();
        step();
        check("abort_no_done", done_seen, exp_done);
        ready_mode = 0;
        start_box(-3, 2047, 5, 1, 1'b0, 1'b0);
        wait_done(40);

        // Reset in the middle of a scan.
        start_box(0, 0, 16, 4, 1'b0, 1'b0);
        step();
        step();
        step();
        i_rst = 1'b1;
        step();
        check("mid_rst_busy_valid", int'({o_busy, o_pixelValid}), 0);
        check("mid_rst_xy", int'({o_pixelX, o_pixelY}), 0);
        check("mid_rst_mask_last_done", int'({o_pairMask, o_lastPixel, o_done}), 0);
        i_rst = 1'b0;
        exp_q.delete();
        exp_done = done_seen;
        step();

        // Boundary crossing +2047 on both axes.
        start_box(2045, 2046, 6, 3, 1'b0, 1'b0);
        wait_done(60);

        // Random boxes under random backpressure.
        ready_mode = 2;
        for (int n = 0; n < 25; n++) begin
            x0 = int'($signed(12'($urandom_range(0, 4095))));
            y0 = int'($signed(12'($urandom_range(0, 4095))));
            w  = $urandom_range(0, 20);
            h  = $urandom_range(0, 7);
            start_box(x0, y0, w, h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done(400);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
